exec_shift_arb: RTL and testbench
=================================

Name: exec_shift_arb

Overview:
- Arbiter and sequencer that shares one combinational shift datapath between two issue requesters (port 0, port 1).
- Round-robin grant, valid/ready handshake on each request port, one-entry registered result stage with valid/ready back-pressure toward writeback.
- Sits between the two issue lanes and the shared shift execution unit; 1-cycle issue-to-result latency when unstalled.

Parameters:
- W_OPR, 32, operand/result width; must be a power of two, >= 8.
- W_SHAMT, 5, shift-amount bits taken from opr1; equals log2(W_OPR).
- W_TAG, 4, opaque requester tag carried with each operation.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 accepted this cycle when valid & ready.
- req0_opr0_i  in  W_OPR  port 0 value to shift.
- req0_opr1_i  in  W_OPR  port 0 shift amount; only [W_SHAMT-1:0] used.
- req0_left_i  in  1  port 0: 1 = shift left logical.
- req0_alith_i  in  1  port 0: right shift is arithmetic when left=0.
- req0_tag_i  in  W_TAG  port 0 tag.
- req1_*  (valid_i, ready_o, opr0_i, opr1_i, left_i, alith_i, tag_i)  same widths/meaning for port 1.
- res_valid_o  out  1  result register holds a valid result.
- res_ready_i  in  1  consumer takes result when valid & ready.
- res_data_o  out  W_OPR  shift result.
- res_tag_o  out  W_TAG  tag of the producing request.
- res_src_o  out  1  port that issued the result (0/1).

Behaviour:
- Reset (async assert, sync release): res_valid_o=0, res_data_o=0, res_tag_o=0, res_src_o=0, last_grant=1 (port 0 wins first contention). req*_ready_o are combinational and read 0 in reset only as a result of the grant logic.
- can_accept = !res_valid_o | res_ready_i (same-cycle drain and refill is allowed).
- Grant: only port 0 valid -> port 0; only port 1 valid -> port 1; both valid -> port != last_grant; neither -> no grant.
- reqK_ready_o = can_accept & grant==K. Never both high in one cycle. ready depends on valid (not ready-before-valid); requesters must not derive valid from ready.
- last_grant updates only on an accepted transfer (valid & ready); stalled contention does not rotate priority.
- On accept: result computed from the granted operands and registered; res_valid_o=1 next cycle; tag and src registered alongside.
- Shift rules: amt = opr1[W_SHAMT-1:0], upper opr1 bits ignored. left=1 -> opr0 << amt (alith ignored). left=0, alith=1 -> arithmetic right shift, sign bit opr0[W_OPR-1] replicated. left=0, alith=0 -> logical right shift, zero fill. amt=0 returns opr0 unchanged in all modes.
- Stall: while res_valid_o & !res_ready_i, res_data_o/res_tag_o/res_src_o hold stable and both ready outputs are 0.
- Drain without refill: res_ready_i=1 and no grant -> res_valid_o=0 next cycle, data registers hold last value.
- Requesters hold all req fields stable while valid & !ready; the arbiter samples only on acceptance.
- Reset mid-operation: in-flight result discarded, state returns to reset values immediately; no partial result emerges after release.
- Throughput: one op per cycle sustained when res_ready_i=1; with both ports saturated, grants alternate 0,1,0,1.

Test Plan:
- Reset, then port 0 only: opr0=0x0000_00F0, opr1=4, left=1, tag=3 -> req0_ready_o=1 that cycle; next cycle res_valid_o=1, res_data_o=0x0000_0F00, res_tag_o=3, res_src_o=0.
- Right-shift modes on port 1: opr0=0x8000_0000, opr1=0x0000_0021 (amt=1): alith=1 -> 0xC000_0000; alith=0 -> 0x4000_0000; amt=0 -> 0x8000_0000.
- Both ports valid every cycle, res_ready_i=1 -> accepts alternate 0,1,0,1 starting with port 0 after reset; one result per cycle, res_src_o tracks order.
- Back-pressure: result valid, res_ready_i=0 for 3 cycles with both ports requesting -> both ready=0, res_data/tag/src unchanged; on res_ready_i=1 the pending winner is accepted the same cycle (drain+refill), priority unchanged by the stall.
- Same-cycle drain+refill: back-to-back ops with res_ready_i=1 -> res_valid_o stays 1 continuously, no bubble.
- Assert rst_n_i low while res_valid_o=1 and res_ready_i=0 -> res_valid_o=0 immediately; after release port 0 wins the first contention.

Source files
------------

// File: rtl/exec_shift_arb_if.sv
// Request/result bundle for exec_shift_arb: two issue ports and one writeback port.
// The slave modport is the arbiter's view; master is the requester/consumer view.
interface exec_shift_arb_if #(
    parameter int W_OPR = 32,
    parameter int W_TAG = 4
);
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [W_OPR-1:0] req0_opr0_i;
    logic [W_OPR-1:0] req0_opr1_i;
    logic             req0_left_i;
    logic             req0_alith_i;
    logic [W_TAG-1:0] req0_tag_i;

    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [W_OPR-1:0] req1_opr0_i;
    logic [W_OPR-1:0] req1_opr1_i;
    logic             req1_left_i;
    logic             req1_alith_i;
    logic [W_TAG-1:0] req1_tag_i;

    logic             res_valid_o;
    logic             res_ready_i;
    logic [W_OPR-1:0] res_data_o;
    logic [W_TAG-1:0] res_tag_o;
    logic             res_src_o;

    modport slave (
        input  req0_valid_i, req0_opr0_i, req0_opr1_i, req0_left_i, req0_alith_i, req0_tag_i,
        input  req1_valid_i, req1_opr0_i, req1_opr1_i, req1_left_i, req1_alith_i, req1_tag_i,
        input  res_ready_i,
        output req0_ready_o, req1_ready_o,
        output res_valid_o, res_data_o, res_tag_o, res_src_o
    );

    modport master (
        output req0_valid_i, req0_opr0_i, req0_opr1_i, req0_left_i, req0_alith_i, req0_tag_i,
        output req1_valid_i, req1_opr0_i, req1_opr1_i, req1_left_i, req1_alith_i, req1_tag_i,
        output res_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  res_valid_o, res_data_o, res_tag_o, res_src_o
    );
endinterface

// File: rtl/exec_shift_arb.sv
// Round-robin arbiter sharing one combinational shifter between two issue ports,
// with a one-entry registered result stage and valid/ready back-pressure.
module exec_shift_arb #(
    parameter int W_OPR   = 32,
    parameter int W_SHAMT = 5,
    parameter int W_TAG   = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    exec_shift_arb_if.slave  bus
);

    localparam logic [W_OPR-1:0] SHAMT_MASK = W_OPR'((1 << W_SHAMT) - 1);

    logic             res_valid_q, res_valid_d;
    logic [W_OPR-1:0] res_data_q,  res_data_d;
    logic [W_TAG-1:0] res_tag_q,   res_tag_d;
    logic             res_src_q,   res_src_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             gnt_valid;
    logic             gnt_port;
    logic             accept;

    logic [W_OPR-1:0] sel_opr0;
    logic [W_OPR-1:0] sel_opr1;
    logic             sel_left;
    logic             sel_alith;
    logic [W_TAG-1:0] sel_tag;
    logic [W_OPR-1:0] amt;
    logic [W_OPR-1:0] shift_res;

    // Result slot is free if empty or being drained this very cycle.
    assign can_accept = !res_valid_q || bus.res_ready_i;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        unique case ({bus.req1_valid_i, bus.req0_valid_i})
            2'b01:   begin gnt_valid = 1'b1; gnt_port = 1'b0;          end
            2'b10:   begin gnt_valid = 1'b1; gnt_port = 1'b1;          end
            2'b11:   begin gnt_valid = 1'b1; gnt_port = !last_grant_q; end
            default: begin gnt_valid = 1'b0; gnt_port = 1'b0;          end
        endcase
    end

    assign accept           = can_accept && gnt_valid;
    assign bus.req0_ready_o = accept && !gnt_port;
    assign bus.req1_ready_o = accept &&  gnt_port;

    always_comb begin
        sel_opr0  = gnt_port ? bus.req1_opr0_i  : bus.req0_opr0_i;
        sel_opr1  = gnt_port ? bus.req1_opr1_i  : bus.req0_opr1_i;
        sel_left  = gnt_port ? bus.req1_left_i  : bus.req0_left_i;
        sel_alith = gnt_port ? bus.req1_alith_i : bus.req0_alith_i;
        sel_tag   = gnt_port ? bus.req1_tag_i   : bus.req0_tag_i;
    end

    // Only the low W_SHAMT bits of opr1 form the shift amount.
    assign amt = sel_opr1 & SHAMT_MASK;

    always_comb begin
        shift_res = '0;
        if (sel_left)
            shift_res = sel_opr0 << amt;
        else if (sel_alith)
            shift_res = W_OPR'($signed(sel_opr0) >>> amt);
        else
            shift_res = sel_opr0 >> amt;
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_tag_d    = res_tag_q;
        res_src_d    = res_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            res_valid_d  = 1'b1;
            res_data_d   = shift_res;
            res_tag_d    = sel_tag;
            res_src_d    = gnt_port;
            last_grant_d = gnt_port;
        end else if (bus.res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_tag_q    <= '0;
            res_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_tag_q    <= res_tag_d;
            res_src_q    <= res_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;
    assign bus.res_tag_o   = res_tag_q;
    assign bus.res_src_o   = res_src_q;

endmodule

// File: tb/tb_exec_shift_arb.sv
// Directed bench for exec_shift_arb: reset, shift modes, alternation, stall, drain, mid-op reset.
module tb_exec_shift_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   c0, c1;
    logic [31:0] exp_data;
    logic [3:0]  exp_tag;
    logic        exp_src;

    always #5 clk = ~clk;

    exec_shift_arb_if #(.W_OPR(32), .W_TAG(4)) bus ();

    exec_shift_arb #(.W_OPR(32), .W_SHAMT(5), .W_TAG(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.req0_valid_i = 1'b0; bus.req0_opr0_i = '0; bus.req0_opr1_i = '0;
        bus.req0_left_i  = 1'b0; bus.req0_alith_i = 1'b0; bus.req0_tag_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_opr0_i = '0; bus.req1_opr1_i = '0;
        bus.req1_left_i  = 1'b0; bus.req1_alith_i = 1'b0; bus.req1_tag_i = '0;
        bus.res_ready_i  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.res_data_o); end
        total++; if (bus.res_tag_o !== 4'h0) begin bad++; $display("FAIL rst_tag got=%h exp=0", bus.res_tag_o); end
        total++; if (bus.res_src_o !== 1'b0) begin bad++; $display("FAIL rst_src got=%b exp=0", bus.res_src_o); end
        total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {bus.req1_ready_o, bus.req0_ready_o}); end
        rst_n = 1'b1;
    endtask

    task automatic test_port0_left();
        @(negedge clk);
        bus.req0_valid_i = 1'b1; bus.req0_opr0_i = 32'h0000_00F0; bus.req0_opr1_i = 32'd4;
        bus.req0_left_i = 1'b1; bus.req0_alith_i = 1'b0; bus.req0_tag_i = 4'd3;
        #1;
        total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin bad++; $display("FAIL p0_ready got=%b exp=01", {bus.req1_ready_o, bus.req0_ready_o}); end
        @(posedge clk); #1;
        bus.req0_valid_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL p0_valid got=%b exp=1", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 32'h0000_0F00) begin bad++; $display("FAIL p0_data got=%h exp=00000f00", bus.res_data_o); end
        total++; if (bus.res_tag_o !== 4'd3) begin bad++; $display("FAIL p0_tag got=%h exp=3", bus.res_tag_o); end
        total++; if (bus.res_src_o !== 1'b0) begin bad++; $display("FAIL p0_src got=%b exp=0", bus.res_src_o); end
    endtask

    task automatic test_port1_shifts();
        logic [31:0] v_opr0 [5];
        logic [31:0] v_opr1 [5];
        logic        v_left [5];
        logic        v_alith[5];
        logic [31:0] v_exp  [5];
        v_opr0[0] = 32'h8000_0000; v_opr1[0] = 32'h21; v_left[0] = 0; v_alith[0] = 1; v_exp[0] = 32'hC000_0000;
        v_opr0[1] = 32'h8000_0000; v_opr1[1] = 32'h21; v_left[1] = 0; v_alith[1] = 0; v_exp[1] = 32'h4000_0000;
        v_opr0[2] = 32'h8000_0000; v_opr1[2] = 32'h20; v_left[2] = 0; v_alith[2] = 1; v_exp[2] = 32'h8000_0000;
        v_opr0[3] = 32'h7000_0000; v_opr1[3] = 32'h04; v_left[3] = 0; v_alith[3] = 1; v_exp[3] = 32'h0700_0000;
        v_opr0[4] = 32'h0000_0003; v_opr1[4] = 32'hFF; v_left[4] = 1; v_alith[4] = 1; v_exp[4] = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req1_valid_i = 1'b1; bus.req1_opr0_i = v_opr0[i]; bus.req1_opr1_i = v_opr1[i];
            bus.req1_left_i = v_left[i]; bus.req1_alith_i = v_alith[i]; bus.req1_tag_i = 4'(i + 4);
            #1;
            total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b10) begin bad++; $display("FAIL sh%0d_ready got=%b exp=10", i, {bus.req1_ready_o, bus.req0_ready_o}); end
            @(posedge clk); #1;
            total++; if (bus.res_data_o !== v_exp[i]) begin bad++; $display("FAIL sh%0d_data got=%h exp=%h", i, bus.res_data_o, v_exp[i]); end
            total++; if (bus.res_tag_o !== 4'(i + 4) || bus.res_src_o !== 1'b1) begin bad++; $display("FAIL sh%0d_tagsrc got=%h/%b exp=%h/1", i, bus.res_tag_o, bus.res_src_o, 4'(i + 4)); end
        end
        bus.req1_valid_i = 1'b0;
    endtask

    task automatic drive_both();
        bus.req0_valid_i = 1'b1; bus.req0_opr0_i = 32'h1; bus.req0_opr1_i = 32'(c0 + 1);
        bus.req0_left_i = 1'b1; bus.req0_alith_i = 1'b0; bus.req0_tag_i = 4'(c0);
        bus.req1_valid_i = 1'b1; bus.req1_opr0_i = 32'h8000_0000; bus.req1_opr1_i = 32'(c1 + 1);
        bus.req1_left_i = 1'b0; bus.req1_alith_i = 1'b0; bus.req1_tag_i = 4'(8 + c1);
    endtask

    task automatic check_result(input string name, input logic src);
        exp_src  = src;
        exp_data = src ? (32'h8000_0000 >> (c1 + 1)) : (32'h1 << (c0 + 1));
        exp_tag  = src ? 4'(8 + c1) : 4'(c0);
        total++; if (bus.res_valid_o !== 1'b1 || bus.res_src_o !== exp_src) begin bad++; $display("FAIL %s_vsrc got=%b/%b exp=1/%b", name, bus.res_valid_o, bus.res_src_o, exp_src); end
        total++; if (bus.res_data_o !== exp_data || bus.res_tag_o !== exp_tag) begin bad++; $display("FAIL %s_data got=%h/%h exp=%h/%h", name, bus.res_data_o, bus.res_tag_o, exp_data, exp_tag); end
        if (src) c1++; else c0++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        c0 = 0; c1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_both();
            #1;
            total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL alt%0d_ready got=%b", i, {bus.req1_ready_o, bus.req0_ready_o}); end
            @(posedge clk); #1;
            check_result($sformatf("alt%0d", i), 1'((i % 2) != 0));
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_both();
        bus.res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin bad++; $display("FAIL bp%0d_ready got=%b exp=00", i, {bus.req1_ready_o, bus.req0_ready_o}); end
            @(posedge clk); #1;
            total++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== exp_data || bus.res_tag_o !== exp_tag || bus.res_src_o !== exp_src)
                begin bad++; $display("FAIL bp%0d_hold got=%b/%h/%h/%b exp=1/%h/%h/%b", i, bus.res_valid_o, bus.res_data_o, bus.res_tag_o, bus.res_src_o, exp_data, exp_tag, exp_src); end
            @(negedge clk);
        end
        bus.res_ready_i = 1'b1;
        #1;
        total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin bad++; $display("FAIL bp_refill_ready got=%b exp=01", {bus.req1_ready_o, bus.req0_ready_o}); end
        @(posedge clk); #1;
        check_result("bp_refill", 1'b0);
        @(negedge clk);
        drive_both();
        #1;
        total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b10) begin bad++; $display("FAIL bp_next_ready got=%b exp=10", {bus.req1_ready_o, bus.req0_ready_o}); end
        @(posedge clk); #1;
        check_result("bp_next", 1'b1);
    endtask

    task automatic test_drain();
        @(negedge clk);
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.res_ready_i = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", bus.res_valid_o); end
        total++; if (bus.res_data_o !== exp_data || bus.res_tag_o !== exp_tag || bus.res_src_o !== exp_src)
            begin bad++; $display("FAIL drain_hold got=%h/%h/%b exp=%h/%h/%b", bus.res_data_o, bus.res_tag_o, bus.res_src_o, exp_data, exp_tag, exp_src); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req1_valid_i = 1'b1; bus.req1_opr0_i = 32'hFF; bus.req1_opr1_i = '0;
        bus.req1_left_i = 1'b0; bus.req1_alith_i = 1'b0; bus.req1_tag_i = 4'd5;
        bus.res_ready_i = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'hFF) begin bad++; $display("FAIL mid_pre got=%b/%h exp=1/000000ff", bus.res_valid_o, bus.res_data_o); end
        @(negedge clk);
        bus.req1_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.res_valid_o !== 1'b0 || bus.res_data_o !== 32'h0 || bus.res_tag_o !== 4'h0)
            begin bad++; $display("FAIL mid_rst got=%b/%h/%h exp=0/0/0", bus.res_valid_o, bus.res_data_o, bus.res_tag_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        c0 = 0; c1 = 0;
        bus.res_ready_i = 1'b1;
        drive_both();
        #1;
        total++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin bad++; $display("FAIL mid_first_ready got=%b exp=01", {bus.req1_ready_o, bus.req0_ready_o}); end
        @(posedge clk); #1;
        check_result("mid_first", 1'b0);
    endtask

    initial begin
        test_reset();
        test_port0_left();
        test_port1_shifts();
        test_back_to_back();
        test_backpressure();
        test_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
